// File: rtl/decoder38_rr_arb.sv
// Round-robin arbiter driving a 3-to-8 line select with a dwell-bounded grant slice and selectable strobe polarity.
// Optional DECODER38_ARB_LOCK_EN adds i_lock, which holds the grant past slice expiry while the holder keeps requesting.
module decoder38_rr_arb #(
  parameter int P_DWELL_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_req,
  input  logic [P_DWELL_W-1:0] i_dwell,
  input  logic                 i_opt,
`ifdef DECODER38_ARB_LOCK_EN
  input  logic                 i_lock,
`endif
  output logic [2:0]           o_sel,
  output logic                 o_valid,
  output logic [7:0]           o_y
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [P_DWELL_W-1:0] cnt;
  logic [2:0]           last;
  logic [2:0]           win;
  logic                 found;
  logic                 any_req;
  logic                 lock_on;
  logic                 rel;
  logic [P_DWELL_W-1:0] reload;

`ifdef DECODER38_ARB_LOCK_EN
  assign lock_on = i_lock;
`else
  assign lock_on = 1'b0;
`endif

  assign any_req = |i_req;
  // A zero dwell still yields a one-cycle slice.
  assign reload  = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
  assign rel     = !i_req[o_sel] || ((cnt == '0) && !lock_on);

  // Scan last+1 .. last+8; the final step revisits the holder itself.
  always_comb begin
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!found && i_req[last + 3'(i)]) begin
        win   = last + 3'(i);
        found = 1'b1;
      end
    end
  end

  function automatic logic [7:0] encode(input logic valid, input logic [2:0] sel, input logic opt);
    logic [7:0] hot;
    hot = valid ? (8'b1 << sel) : 8'h00;
    return opt ? hot : ~hot;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_sel   <= 3'd0;
      o_y     <= 8'hFF;
      cnt     <= '0;
      last    <= 3'd7;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= GRANT;
            o_valid <= 1'b1;
            o_sel   <= win;
            last    <= win;
            cnt     <= reload;
            o_y     <= encode(1'b1, win, i_opt);
          end else begin
            o_y <= encode(1'b0, o_sel, i_opt);
          end
        end
        GRANT: begin
          if (!rel) begin
            // Only a lock can keep us here at zero; the counter saturates then.
            if (cnt != '0) cnt <= cnt - 1'b1;
            o_y <= encode(1'b1, o_sel, i_opt);
          end else if (any_req) begin
            o_sel <= win;
            last  <= win;
            cnt   <= reload;
            o_y   <= encode(1'b1, win, i_opt);
          end else begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_y     <= encode(1'b0, o_sel, i_opt);
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder38_rr_arb.sv
// Directed bench for decoder38_rr_arb; the lock scenario runs only when DECODER38_ARB_LOCK_EN is defined.
module tb_decoder38_rr_arb;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_req;
  logic [7:0] i_dwell;
  logic       i_opt;
`ifdef DECODER38_ARB_LOCK_EN
  logic       i_lock;
`endif
  logic [2:0] o_sel;
  logic       o_valid;
  logic [7:0] o_y;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  decoder38_rr_arb #(.P_DWELL_W(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_dwell (i_dwell),
    .i_opt   (i_opt),
`ifdef DECODER38_ARB_LOCK_EN
    .i_lock  (i_lock),
`endif
    .o_sel   (o_sel),
    .o_valid (o_valid),
    .o_y     (o_y)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = 8'hFF; i_dwell = 8'd3; i_opt = 1'b0;
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", o_valid); end
    tests++; if (o_y !== 8'hFF) begin fails++; $display("FAIL reset_y got %h want ff", o_y); end
    tests++; if (o_sel !== 3'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", o_sel); end
    i_rst = 1'b0;
    tick();
    tests++; if (o_sel !== 3'd0) begin fails++; $display("FAIL first_grant_sel got %0d want 0", o_sel); end
    tests++; if (o_y !== 8'hFE) begin fails++; $display("FAIL first_grant_y got %h want fe", o_y); end
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL first_grant_valid got %b want 1", o_valid); end
  endtask

  task automatic test_rotation();
    logic [2:0] g;
    logic [7:0] hot;
    do_reset();
    i_req = 8'hFF; i_dwell = 8'd3; i_opt = 1'b0;
    for (int n = 0; n < 9; n++) begin
      g   = 3'(n);
      hot = 8'b1 << g;
      for (int c = 0; c < 3; c++) begin
        tick();
        tests++; if (o_sel !== g) begin fails++; $display("FAIL rot_sel n=%0d c=%0d got %0d want %0d", n, c, o_sel, g); end
        tests++; if (o_y !== ~hot) begin fails++; $display("FAIL rot_y n=%0d c=%0d got %h want %h", n, c, o_y, ~hot); end
        tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL rot_valid n=%0d got %b want 1", n, o_valid); end
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    i_req = 8'h20; i_dwell = 8'd10; i_opt = 1'b0;
    tick();
    tests++; if (o_sel !== 3'd5) begin fails++; $display("FAIL er_grant5 got %0d want 5", o_sel); end
    i_req = 8'h24;
    tick();
    tests++; if (o_sel !== 3'd5) begin fails++; $display("FAIL er_hold5 got %0d want 5", o_sel); end
    i_req = 8'h04; i_dwell = 8'd0;
    tick();
    tests++; if (o_sel !== 3'd2) begin fails++; $display("FAIL er_switch2 got %0d want 2", o_sel); end
    tests++; if (o_y !== 8'hFB) begin fails++; $display("FAIL er_y2 got %h want fb", o_y); end
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL zd_valid c=%0d got %b want 1", c, o_valid); end
      tests++; if (o_sel !== 3'd2) begin fails++; $display("FAIL zd_sel c=%0d got %0d want 2", c, o_sel); end
    end
    // One-cycle slice means a new contender wins immediately.
    i_req = 8'h0C;
    tick();
    tests++; if (o_sel !== 3'd3) begin fails++; $display("FAIL zd_contender got %0d want 3", o_sel); end
  endtask

  task automatic test_polarity_idle();
    do_reset();
    i_opt = 1'b1; i_req = 8'h80; i_dwell = 8'd2;
    tick();
    tests++; if (o_sel !== 3'd7) begin fails++; $display("FAIL pol_sel got %0d want 7", o_sel); end
    tests++; if (o_y !== 8'h80) begin fails++; $display("FAIL pol_y_hot got %h want 80", o_y); end
    i_req = 8'h00;
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %b want 0", o_valid); end
    tests++; if (o_y !== 8'h00) begin fails++; $display("FAIL idle_y_hot got %h want 00", o_y); end
    i_opt = 1'b0;
    tick();
    tests++; if (o_y !== 8'hFF) begin fails++; $display("FAIL idle_y_cold got %h want ff", o_y); end
    tests++; if (o_sel !== 3'd7) begin fails++; $display("FAIL idle_sel_hold got %0d want 7", o_sel); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_opt = 1'b0; i_req = 8'h08; i_dwell = 8'd4;
    tick();
    tick();
    tests++; if (o_sel !== 3'd3) begin fails++; $display("FAIL mr_before got %0d want 3", o_sel); end
    i_rst = 1'b1;
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mr_valid got %b want 0", o_valid); end
    tests++; if (o_sel !== 3'd0) begin fails++; $display("FAIL mr_sel got %0d want 0", o_sel); end
    tests++; if (o_y !== 8'hFF) begin fails++; $display("FAIL mr_y got %h want ff", o_y); end
    i_rst = 1'b0;
    tick();
    tests++; if (o_sel !== 3'd3) begin fails++; $display("FAIL mr_regrant got %0d want 3", o_sel); end
    tests++; if (o_y !== 8'hF7) begin fails++; $display("FAIL mr_regrant_y got %h want f7", o_y); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_sel [6];
    exp_sel = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    do_reset();
    i_opt = 1'b0; i_req = 8'h03; i_dwell = 8'd1;
    tick();
    // Grant to 1 samples the new dwell of 5; grant to 0 keeps its 1-cycle slice.
    i_dwell = 8'd5;
    for (int c = 1; c < 6; c++) begin
      tick();
      tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid c=%0d got %b want 1", c, o_valid); end
      tests++; if (o_sel !== exp_sel[c]) begin fails++; $display("FAIL b2b_sel c=%0d got %0d want %0d", c, o_sel, exp_sel[c]); end
    end
    tick();
    tests++; if (o_sel !== 3'd0) begin fails++; $display("FAIL b2b_wrap got %0d want 0", o_sel); end
  endtask

`ifdef DECODER38_ARB_LOCK_EN
  task automatic test_lock();
    i_lock = 1'b0;
    do_reset();
    i_opt = 1'b0; i_req = 8'h03; i_dwell = 8'd2; i_lock = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (o_sel !== 3'd0) begin fails++; $display("FAIL lock_hold c=%0d got %0d want 0", c, o_sel); end
    end
    i_lock = 1'b0;
    tick();
    tests++; if (o_sel !== 3'd1) begin fails++; $display("FAIL lock_release got %0d want 1", o_sel); end
  endtask
`endif

  initial begin
`ifdef DECODER38_ARB_LOCK_EN
    i_lock = 1'b0;
`endif
    test_reset();
    test_rotation();
    test_early_release();
    test_polarity_idle();
    test_mid_reset();
    test_back_to_back();
`ifdef DECODER38_ARB_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decoder38_rr_arb.md
# decoder38_rr_arb

Round-robin arbiter that shares the 3-to-8 line select among eight requesters. It produces the granted index on `o_sel` and the decoded one-of-eight strobe on `o_y`, with selectable polarity: active-low one-cold or active-high one-hot. It sits in front of the 3-8 decoder datapath, sequencing which output line is driven and for how long; each grant is a time slice bounded by a programmable dwell.

## Interface
- `P_DWELL_W`, default 8: width of the dwell (time-slice) counter and of `i_dwell`.
- `i_clk` in 1: the only clock; all state updates on its rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req` in 8: request vector; bit n = requester n wants the line.
- `i_dwell` in `P_DWELL_W`: maximum grant length in cycles; 0 is treated as 1; sampled when a grant is issued.
- `i_opt` in 1: output polarity; 0 = active-low one-cold, 1 = active-high one-hot; sampled every cycle.
- `o_sel` out 3: index of the current grant; holds last value when idle.
- `o_valid` out 1: a grant is active.
- `o_y` out 8: registered decoded strobe for `o_sel`, or all-inactive when `o_valid`=0.

## Operation
- Two-state FSM: IDLE, GRANT.
- Registers:
  - `o_sel`, `o_valid`, `o_y`.
  - Dwell counter `cnt`, `P_DWELL_W` bits.
  - Priority pointer `last` (3 bits).
- Winner selection: the first set bit of `i_req` scanning `last+1, last+2, …` modulo 8; `last` wraps 7→0.
- IDLE:
  - If `i_req`≠0: go to GRANT. Set `o_sel`=winner, `last`=winner, `cnt`=max(`i_dwell`,1)−1, `o_valid`=1.
  - Otherwise stay in IDLE.
- GRANT, release condition: `i_req[o_sel]`=0 (early release) or `cnt`=0 (slice expired).
- GRANT without a release condition: `cnt` decrements; the grant is held.
- GRANT with a release condition, arbitrating in the same cycle:
  - Another requester set: grant it next cycle (no idle bubble) and reload `cnt`.
  - Only the current holder still requesting (`cnt`=0 case): re-grant the same index and reload `cnt`.
  - No requests: go to IDLE with `o_valid`=0.
- `o_y` encoding:
  - `o_valid`=1, `i_opt`=0: `~(8'b1 << o_sel)`.
  - `o_valid`=1, `i_opt`=1: `8'b1 << o_sel`.
  - `o_valid`=0: 8'hFF if `i_opt`=0, 8'h00 if `i_opt`=1.
- Requests are level-sensitive; the block has no request memory, and a requester must hold its request until granted.

## Timing
- Reset values: state=IDLE, `o_valid`=0, `o_sel`=0, `o_y`=8'hFF, `cnt`=0, `last`=7, so requester 0 wins the first arbitration.
- `i_rst` has priority over everything. Asserting it mid-grant returns all reset values at the next edge and discards the slice.
- Grant latency: a request sampled at edge k yields `o_valid`, `o_sel`, `o_y` updated after edge k (1 cycle).
- Slice length: a continuously requesting holder with contenders present keeps the grant for exactly max(`i_dwell`,1) cycles.
- Early release: the request is seen low at edge k; the next grant or IDLE is visible after edge k.
- Back-to-back grants have zero bubble cycles.
- An `i_opt` change is reflected in `o_y` one cycle later; the grant is unaffected.
- A change to `i_dwell` during a grant affects only the next grant.

## Configuration
- `DECODER38_ARB_LOCK_EN` defined:
  - Adds input `i_lock` (1 bit).
  - In GRANT with `i_lock`=1, slice expiry is ignored: `cnt` saturates at 0 and the grant is held while `i_req[o_sel]`=1.
  - Early release on a request drop still applies.
  - `i_lock` has no effect in IDLE.
- Not defined: no `i_lock` port; expiry always forces re-arbitration.

## Test plan
- Reset: assert `i_rst` with `i_req`=8'hFF → after edge `o_valid`=0, `o_y`=8'hFF, `o_sel`=0. Release → next edge `o_sel`=0, `o_y`=8'hFE.
- Rotation: `i_req`=8'hFF, `i_dwell`=3, `i_opt`=0 → `o_sel` steps 0,1,…,7,0, each for exactly 3 cycles, with `o_y` one-cold at each index.
- Early release plus zero dwell: grant 5 with `i_dwell`=10, drop `i_req[5]` after 2 cycles with `i_req[2]` set → `o_sel`=2 the next cycle. Then `i_dwell`=0 with only requester 2 → re-granted every cycle, `o_valid` never drops.
- Polarity and idle: `i_opt`=1, single request 7 → `o_y`=8'h80. Drop all requests → next cycle `o_valid`=0, `o_y`=8'h00. Toggle `i_opt` to 0 → `o_y`=8'hFF one cycle later.
- Mid-grant reset: assert `i_rst` during the 2nd cycle of a 4-cycle slice on index 3 → reset values. With `i_req`=8'h08 after release, index 3 is granted, since `last`=7 restarts the scan from requester 0.
- Lock (macro defined): `i_lock`=1, `i_req`=8'h03, `i_dwell`=2, holder 0 → grant stays at 0 beyond 2 cycles. Deassert `i_lock` → `o_sel`=1 one cycle later.
